// File: rtl/trackball_pkg.sv
// Shared definitions for the trackball quadrature emulator: the Gray phase
// encoding, accumulator bounds and the saturation helper.
package trackball_pkg;

  // {D,C} line levels for phase index p = 0..3
  localparam logic [1:0] PHASE_DC [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int acc_max(input int unsigned acc_w);
    return (int'(1) <<< (acc_w - 1)) - 1;
  endfunction

  // Symmetric clamp to [-acc_max, +acc_max]; excess movement is dropped.
  function automatic int sat_acc(input int v, input int unsigned acc_w);
    int lim;
    lim = acc_max(acc_w);
    if (v > lim) begin
      return lim;
    end else if (v < -lim) begin
      return -lim;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: scaled delta intake, saturating accumulator, and a
// phase stepper that moves one Gray step toward zero on each tick.
module trackball_axis
  import trackball_pkg::*;
#(
  parameter int unsigned ACC_W      = 10,
  parameter int unsigned SENS_SHIFT = 0,
  parameter bit          NEGATE     = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       strobe,
  input  logic [8:0] delta,
  output logic       ph_d,
  output logic       ph_c,
  output logic       busy
);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [1:0]              p;
  logic [1:0]              p_next;
  int                      d;
  int                      s;
  int                      sum;

  // Arithmetic is carried in int width so negating the most negative scaled
  // delta cannot wrap before the clamp.
  always_comb begin
    d = int'($signed(delta)) <<< SENS_SHIFT;
    if (NEGATE) begin
      d = -d;
    end
    s      = 0;
    p_next = p;
    if (tick && (acc != '0)) begin
      if (!acc[ACC_W-1]) begin
        s      = 1;
        p_next = p + 2'd1;
      end else begin
        s      = -1;
        p_next = p - 2'd1;
      end
    end
    sum      = int'(acc) + (strobe ? d : 0) - s;
    acc_next = ACC_W'(sat_acc(sum, ACC_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      p    <= '0;
      ph_d <= 1'b0;
      ph_c <= 1'b0;
      busy <= 1'b0;
    end else begin
      acc          <= acc_next;
      p            <= p_next;
      {ph_d, ph_c} <= PHASE_DC[p_next];
      busy         <= (acc_next != '0);
    end
  end

endmodule

// File: rtl/trackball_quadrature_gen.sv
// Mouse-report to trackball quadrature converter: shared step prescaler,
// button synchronizer and two independent axis steppers.
module trackball_quadrature_gen
  import trackball_pkg::*;
#(
  parameter int unsigned STEP_DIV   = 1000,
  parameter int unsigned ACC_W      = 10,
  parameter int unsigned SENS_SHIFT = 0,
  parameter int unsigned INVERT_Y   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mouse_strobe,
  input  logic [8:0] mouse_dx,
  input  logic [8:0] mouse_dy,
  input  logic       mouse_btn,
  output logic       tb_hd,
  output logic       tb_hc,
  output logic       tb_vd,
  output logic       tb_vc,
  output logic       tb_jmp,
  output logic       h_busy,
  output logic       v_busy
);

  localparam int unsigned      CNT_W  = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] pre_cnt;
  logic             tick;
  logic             btn_meta;

  assign tick = (pre_cnt == '0);

  // Free-running; strobes never restart it, so step spacing stays exact.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt <= RELOAD;
    end else if (tick) begin
      pre_cnt <= RELOAD;
    end else begin
      pre_cnt <= pre_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_meta <= 1'b0;
      tb_jmp   <= 1'b0;
    end else begin
      btn_meta <= mouse_btn;
      tb_jmp   <= btn_meta;
    end
  end

  trackball_axis #(
    .ACC_W      (ACC_W),
    .SENS_SHIFT (SENS_SHIFT),
    .NEGATE     (1'b0)
  ) u_axis_h (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .strobe  (mouse_strobe),
    .delta   (mouse_dx),
    .ph_d    (tb_hd),
    .ph_c    (tb_hc),
    .busy    (h_busy)
  );

  trackball_axis #(
    .ACC_W      (ACC_W),
    .SENS_SHIFT (SENS_SHIFT),
    .NEGATE     (INVERT_Y != 0)
  ) u_axis_v (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick),
    .strobe  (mouse_strobe),
    .delta   (mouse_dy),
    .ph_d    (tb_vd),
    .ph_c    (tb_vc),
    .busy    (v_busy)
  );

endmodule
